tx_serial: RTL and testbench

TX_SERIAL -- requirements
Module: tx_serial

---
 rtl/tx_serial_pkg.sv | 16 +
 rtl/tx_serial_if.sv | 26 ++
 rtl/tx_serial_fifo.sv | 56 +++++
 rtl/tx_serial.sv | 130 +++++++++++++
 tb/tb_tx_serial.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_serial_pkg.sv
// Shared constants and types for the tx_serial frame transmitter.
package tx_serial_pkg;

    localparam int   FRAME_BITS = 9;     // 8 data slots + 1 delimiter slot
    localparam int   DATA_BITS  = 8;
    localparam logic DELIM_BIT  = 1'b0;  // value driven in the last slot of every frame
    localparam int   FIFO_DEPTH = 4;

    // LOAD: first clock of slot 0; SHIFT: rest of slots 0..7; DELIM: slot 8
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        DELIM = 2'd2
    } tx_state_e;

endpackage

// File: rtl/tx_serial_if.sv
// Byte input handshake and serial output bundle for tx_serial.
//
// Handshake: a byte moves on a rising edge where in_valid=1 and in_ready=1;
// in_data is sampled on that edge. in_ready never depends on in_valid, and
// in_data/in_valid are ignored while in_ready=0.
interface tx_serial_if;
    import tx_serial_pkg::*;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       txd;
    logic       frame_start;
    logic       frame_idle;
    tx_state_e  state;      // transmitter FSM state, for observation only

    modport master (
        output in_data, in_valid,
        input  in_ready, txd, frame_start, frame_idle, state
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, txd, frame_start, frame_idle, state
    );
endinterface

// File: rtl/tx_serial_fifo.sv
// 4-entry synchronous byte FIFO with full/empty flags; head is always on dout.
module tx_serial_fifo
    import tx_serial_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/tx_serial.sv
// Continuous framed serial transmitter. Every frame is 9 slots of DIV clocks:
// 8 data bits MSB first, then a 0 delimiter. Frames run back to back; a frame
// with no pending user byte carries IDLE_WORD and raises frame_idle.
// Build option TX_SERIAL_FIFO_EN swaps the single holding register for a
// 4-entry FIFO; ports and frame timing are identical in both builds.
module tx_serial
    import tx_serial_pkg::*;
#(
    parameter logic [7:0] IDLE_WORD = 8'h00,
    parameter int         DIV       = 1
)(
    input  logic        clk,
    input  logic        rst,
    tx_serial_if.slave  bus
);
    logic [DATA_BITS-1:0] shreg;
    logic [3:0]           slot;
    logic [7:0]           div_cnt;
    logic                 run;       // 0 until the first frame has been loaded
    tx_state_e            state;
    logic                 txd_q;
    logic                 frame_start_q;
    logic                 frame_idle_q;

    logic                 last_clk;
    logic                 load;
    logic                 accept;
    logic                 head_valid;
    logic [7:0]           head_data;
    logic                 pop;

    assign last_clk = (div_cnt == 8'(DIV - 1));
    // Load edge: first edge out of reset, or the last clock of the delimiter slot.
    assign load     = !rst && (!run || ((slot == 4'(FRAME_BITS - 1)) && last_clk));
    assign accept   = bus.in_valid && bus.in_ready;
    assign pop      = load && head_valid;

`ifdef TX_SERIAL_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    tx_serial_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .din   (bus.in_data),
        .dout  (head_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_valid   = !fifo_empty;
    assign bus.in_ready = !rst && !fifo_full;
`else
    logic       hold_full;
    logic [7:0] hold_data;

    // Single holding register: filled on accept, freed when a frame loads it.
    // Accept needs it empty and pop needs it full, so both never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= bus.in_data;
        end else if (pop) begin
            hold_full <= 1'b0;
        end
    end

    assign head_valid   = hold_full;
    assign head_data    = hold_data;
    assign bus.in_ready = !rst && !hold_full;
`endif

    // Frame FSM with registered line outputs: loads a frame, then steps slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg         <= IDLE_WORD;
            slot          <= '0;
            div_cnt       <= '0;
            run           <= 1'b0;
            state         <= LOAD;
            txd_q         <= IDLE_WORD[7];
            frame_start_q <= 1'b0;
            frame_idle_q  <= 1'b1;
        end else if (load) begin
            run           <= 1'b1;
            slot          <= '0;
            div_cnt       <= '0;
            state         <= LOAD;
            frame_start_q <= 1'b1;
            if (head_valid) begin
                shreg        <= head_data;
                txd_q        <= head_data[7];
                frame_idle_q <= 1'b0;
            end else begin
                shreg        <= IDLE_WORD;
                txd_q        <= IDLE_WORD[7];
                frame_idle_q <= 1'b1;
            end
        end else begin
            frame_start_q <= 1'b0;
            if (last_clk) begin
                div_cnt <= '0;
                slot    <= slot + 4'd1;
                if (slot == 4'(DATA_BITS - 1)) begin
                    txd_q <= DELIM_BIT;
                    state <= DELIM;
                end else begin
                    shreg <= {shreg[DATA_BITS-2:0], 1'b0};
                    txd_q <= shreg[DATA_BITS-2];
                    state <= SHIFT;
                end
            end else begin
                div_cnt <= div_cnt + 8'd1;
                if (state == LOAD) begin
                    state <= SHIFT;
                end
            end
        end
    end

    assign bus.txd         = txd_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_idle  = frame_idle_q;
    assign bus.state       = state;
endmodule

// File: tb/tb_tx_serial.sv
// Bench for tx_serial: two instances (DIV=1 / IDLE 0x00 and DIV=3 / IDLE 0xC3)
// share clock and reset, each compared every cycle to a frame-position model.
module tb_tx_serial;
    import tx_serial_pkg::*;

`ifdef TX_SERIAL_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    tx_serial_if bus1 ();
    tx_serial_if bus3 ();

    tx_serial #(.IDLE_WORD(8'h00), .DIV(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    tx_serial #(.IDLE_WORD(8'hC3), .DIV(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // observed outputs after the latest edge, per instance
    logic o_txd [2];
    logic o_fs  [2];
    logic o_idle[2];
    logic o_rdy [2] = '{1'b0, 1'b0};

    // reference model state: edges since reset release, pending bytes, current frame
    int         m_t  [2];
    int         m_n  [2];
    logic [7:0] m_q  [2][4];
    logic [7:0] m_cur[2];
    logic       m_idle[2];
    logic       m_rst[2];

    function automatic int div_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] idle_of(input int k);
        return (k == 0) ? 8'h00 : 8'hC3;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_edge(input int k, input logic r, input logic v, input logic [7:0] d);
        int   p;
        logic rdy;
        m_rst[k] = r;
        if (r) begin
            m_t[k]    = 0;
            m_n[k]    = 0;
            m_cur[k]  = idle_of(k);
            m_idle[k] = 1'b1;
        end else begin
            rdy = (m_n[k] < CAP);
            m_t[k]++;
            p = (m_t[k] - 1) % (9 * div_of(k));
            if (p == 0) begin
                if (m_n[k] > 0) begin
                    m_cur[k]  = m_q[k][0];
                    for (int i = 0; i < 3; i++) m_q[k][i] = m_q[k][i+1];
                    m_n[k]--;
                    m_idle[k] = 1'b0;
                end else begin
                    m_cur[k]  = idle_of(k);
                    m_idle[k] = 1'b1;
                end
            end
            if (v && rdy) begin
                m_q[k][m_n[k]] = d;
                m_n[k]++;
            end
        end
    endtask

    task automatic check_model(input int k);
        int   p;
        int   s;
        logic e_txd;
        logic e_fs;
        if (m_t[k] == 0) begin
            e_txd = m_cur[k][7];
            e_fs  = 1'b0;
        end else begin
            p     = (m_t[k] - 1) % (9 * div_of(k));
            s     = p / div_of(k);
            e_txd = (s < 8) ? m_cur[k][7 - s] : 1'b0;
            e_fs  = (p == 0);
        end
        check($sformatf("model%0d_txd t=%0d", k, m_t[k]), o_txd[k], e_txd);
        check($sformatf("model%0d_frame_start t=%0d", k, m_t[k]), o_fs[k], e_fs);
        check($sformatf("model%0d_frame_idle t=%0d", k, m_t[k]), o_idle[k], m_idle[k]);
        check($sformatf("model%0d_in_ready t=%0d", k, m_t[k]), o_rdy[k],
              (!m_rst[k] && (m_n[k] < CAP)) ? 1 : 0);
    endtask

    // one clock: drive inputs, take the edge, sample at the falling edge, check
    task automatic step(input logic r, input logic v1, input logic [7:0] d1,
                        input logic v3, input logic [7:0] d3);
        rst           = r;
        bus1.in_valid = v1;
        bus1.in_data  = d1;
        bus3.in_valid = v3;
        bus3.in_data  = d3;
        @(posedge clk);
        model_edge(0, r, v1, d1);
        model_edge(1, r, v3, d3);
        @(negedge clk);
        o_txd[0] = bus1.txd; o_fs[0] = bus1.frame_start; o_idle[0] = bus1.frame_idle; o_rdy[0] = bus1.in_ready;
        o_txd[1] = bus3.txd; o_fs[1] = bus3.frame_start; o_idle[1] = bus3.frame_idle; o_rdy[1] = bus3.in_ready;
        check_model(0);
        check_model(1);
    endtask

    task automatic do_reset();
        repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    // Push up to nb bytes into instance 0 with valid held, record the line,
    // then decode frames and require the bytes in consecutive user frames.
    task automatic send_frames(input string tag, input int nb, input logic [7:0] bl [5],
                               input int nsteps, output int acc5, output logic rdy_first,
                               output logic rdy4);
        logic       r_txd [100];
        logic       r_fs  [100];
        logic       r_idle[100];
        logic [7:0] fb[$];
        logic       fi[$];
        logic [7:0] byt;
        int         idx;
        int         j;
        int         got;
        logic       v;
        logic       acc;
        idx = 0; acc5 = 0; rdy_first = 1'b1; rdy4 = 1'b1;
        for (int s = 0; s < nsteps; s++) begin
            v   = (idx < nb);
            acc = v && o_rdy[0];
            step(1'b0, v, bl[(idx < 5) ? idx : 0], 1'b0, 8'h00);
            if (acc) begin
                if (idx == 0) rdy_first = o_rdy[0];
                idx++;
                if (s < 5) acc5++;
            end
            if (s == 3) rdy4 = o_rdy[0];
            r_txd[s] = o_txd[0]; r_fs[s] = o_fs[0]; r_idle[s] = o_idle[0];
        end
        for (int s = 0; s + 8 < nsteps; s++) begin
            if (r_fs[s]) begin
                for (int b = 0; b < 8; b++) byt[7 - b] = r_txd[s + b];
                fb.push_back(byt);
                fi.push_back(r_idle[s]);
            end
        end
        j = -1;
        for (int i = 0; i < fi.size(); i++) if (j < 0 && !fi[i]) j = i;
        for (int m = 0; m < nb; m++) begin
            got = (j >= 0 && j + m < fb.size()) ? {23'd0, fi[j+m], fb[j+m]} : 'h1ff;
            check($sformatf("%s_frame%0d", tag, m), got, {24'd0, bl[m]});
        end
    endtask

    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] d;
        logic       e_txd;
        logic       e_fs;
        logic       e_idle;
        logic       e_rdy;
    } tv_t;

    function automatic tv_t tv(input logic r, input logic v, input logic [7:0] d,
                               input logic t, input logic fs, input logic idle, input logic rdy);
        tv_t x;
        x.r = r; x.v = v; x.d = d; x.e_txd = t; x.e_fs = fs; x.e_idle = idle; x.e_rdy = rdy;
        return x;
    endfunction

    initial begin
        tv_t        tab[22];
        logic       acc_rdy;
        logic [7:0] a5;
        logic [7:0] bl[5];
        int         waited;
        int         seen;
        int         acc5;
        logic       rdy_first;
        logic       rdy4;
        logic       pat;

        // ---- table: reset, idle frames, 0xA5 offered on the first cycle out of reset
        acc_rdy = (CAP > 1);
        a5      = 8'hA5;
        for (int i = 0; i < 3; i++)   tab[i] = tv(1, 0, 8'h00, 0, 0, 1, 0);
        tab[3] = tv(0, 1, 8'hA5, 0, 1, 1, acc_rdy);
        for (int i = 4; i < 12; i++)  tab[i] = tv(0, 0, 8'h00, 0, 0, 1, acc_rdy);
        for (int i = 12; i < 20; i++) tab[i] = tv(0, 0, 8'h00, a5[7 - (i - 12)], (i == 12), 0, 1);
        tab[20] = tv(0, 0, 8'h00, 0, 0, 0, 1);
        tab[21] = tv(0, 0, 8'h00, 0, 1, 1, 1);
        for (int i = 0; i < 22; i++) begin
            step(tab[i].r, tab[i].v, tab[i].d, 1'b0, 8'h00);
            check($sformatf("tab%0d_txd", i), o_txd[0], tab[i].e_txd);
            check($sformatf("tab%0d_frame_start", i), o_fs[0], tab[i].e_fs);
            check($sformatf("tab%0d_frame_idle", i), o_idle[0], tab[i].e_idle);
            check($sformatf("tab%0d_in_ready", i), o_rdy[0], tab[i].e_rdy);
        end

        // ---- DIV=3, 0x81: 3 ones, 18 zeros, 3 ones, 3 delimiter zeros, 27 clocks
        do_reset();
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h81);
        waited = 0;
        while (!(o_fs[1] && !o_idle[1]) && waited < 60) begin
            step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
            waited++;
        end
        check("div3_frame_found", (o_fs[1] && !o_idle[1]) ? 1 : 0, 1);
        for (int i = 0; i < 27; i++) begin
            pat = (i < 3) || (i >= 21 && i < 24);
            check($sformatf("div3_txd_clk%0d", i), o_txd[1], pat);
            step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        end
        check("div3_next_frame_start", o_fs[1], 1);

        // ---- valid held with 0x11, 0x22, 0x33: consecutive user frames
        do_reset();
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        bl = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00};
        send_frames("stream3", 3, bl, 60, acc5, rdy_first, rdy4);
        check("stream3_ready_after_first", rdy_first, (CAP > 1) ? 1 : 0);

`ifdef TX_SERIAL_FIFO_EN
        // ---- five back-to-back pushes during an idle frame
        do_reset();
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        bl = '{8'h01, 8'h82, 8'h43, 8'hC4, 8'h25};
        send_frames("fifo5", 5, bl, 70, acc5, rdy_first, rdy4);
        check("fifo5_accepted_before_pop", acc5, 4);
        check("fifo5_ready_when_full", rdy4, 0);
`endif

        // ---- reset at slot 4 of a 0x5A frame: frame aborted, never resumed
        do_reset();
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h5A, 1'b1, 8'h5A);
        waited = 0;
        while (!(o_fs[0] && !o_idle[0]) && waited < 40) begin
            step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
            waited++;
        end
        check("abort_frame_found", (o_fs[0] && !o_idle[0]) ? 1 : 0, 1);
        repeat (4) step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("abort_slot4_txd", o_txd[0], 1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("abort_post_frame_start", o_fs[0], 1);
        check("abort_post_frame_idle", o_idle[0], 1);
        seen = 0;
        repeat (40) begin
            step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
            if ((o_fs[0] && !o_idle[0]) || (o_fs[1] && !o_idle[1])) seen++;
        end
        check("abort_no_resume", seen, 0);

        // ---- randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
